// File: rtl/regwrite_port_arbiter_if.sv
// Register-file write port bundle: the A and B requester handshakes plus the
// registered write port (enable/address/data/mux select) driven by the arbiter.
interface regwrite_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              reqa_valid;
  logic [ADDR_W-1:0] reqa_addr;
  logic [DATA_W-1:0] reqa_data;
  logic              reqa_last;
  logic              reqa_ready;

  logic              reqb_valid;
  logic [ADDR_W-1:0] reqb_addr;
  logic [DATA_W-1:0] reqb_data;
  logic              reqb_last;
  logic              reqb_ready;

  logic              sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;

  // The arbiter side: consumes both request channels, drives the write port.
  modport slave (
    input  reqa_valid, reqa_addr, reqa_data, reqa_last,
    input  reqb_valid, reqb_addr, reqb_data, reqb_last,
    output reqa_ready, reqb_ready,
    output sel, wr_en, wr_addr, wr_data, busy
  );

  modport master (
    output reqa_valid, reqa_addr, reqa_data, reqa_last,
    output reqb_valid, reqb_addr, reqb_data, reqb_last,
    input  reqa_ready, reqb_ready,
    input  sel, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/regwrite_port_arbiter.sv
// Round-robin burst arbiter sharing the register file write port between the
// matrix-multiply accumulate unit (A) and the load/ALU writeback path (B).
module regwrite_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  regwrite_port_arbiter_if.slave bus
);
  localparam int               CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last_b;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  beat_cnt_inc;
  logic              xfer_a;
  logic              xfer_b;
  logic              xfer;
  logic              xfer_last;
  logic              burst_end;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;

  // Ready is decoded from state alone, so a beat moves whenever the owner is valid.
  assign xfer_a       = (state == OWN_A) && bus.reqa_valid;
  assign xfer_b       = (state == OWN_B) && bus.reqb_valid;
  assign xfer         = xfer_a || xfer_b;
  assign xfer_last    = xfer_a ? bus.reqa_last : bus.reqb_last;
  assign xfer_addr    = xfer_a ? bus.reqa_addr : bus.reqb_addr;
  assign xfer_data    = xfer_a ? bus.reqa_data : bus.reqb_data;
  assign beat_cnt_inc = beat_cnt + CNT_W'(1);
  assign burst_end    = xfer && (xfer_last || (beat_cnt_inc == CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hand-off goes straight to the other requester when it is waiting, so the
  // write port never sees a bubble between grants.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.reqa_valid && (!bus.reqb_valid || last_b)) begin
          state_next = OWN_A;
        end else if (bus.reqb_valid) begin
          state_next = OWN_B;
        end
      end
      OWN_A: begin
        if (burst_end) begin
          state_next = bus.reqb_valid ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (burst_end) begin
          state_next = bus.reqa_valid ? OWN_A : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.reqa_ready = (state == OWN_A);
    bus.reqb_ready = (state == OWN_B);
    bus.busy       = (state != IDLE);
  end

  // The beat count only moves on a transfer and is cleared at every burst end,
  // which is also the only way to leave a grant, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      last_b   <= 1'b1;
    end else if (burst_end) begin
      beat_cnt <= '0;
      last_b   <= xfer_b;
    end else if (xfer) begin
      beat_cnt <= beat_cnt_inc;
    end
  end

  // Register-0 writes complete the handshake but never assert the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.sel     <= 1'b0;
    end else if (xfer) begin
      bus.wr_en   <= (xfer_addr != '0);
      bus.wr_addr <= xfer_addr;
      bus.wr_data <= xfer_data;
      bus.sel     <= xfer_a;
    end else begin
      bus.wr_en   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regwrite_port_arbiter.sv
// Self-checking bench for regwrite_port_arbiter: directed vector table, a few
// multi-cycle sequences, and randomized traffic against a burst-level model.
module tb_regwrite_port_arbiter;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;

  regwrite_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  regwrite_port_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    bit          readyA;
    bit          readyB;
    bit          busy;
    bit          wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    bit          sel;
  } outs_t;

  typedef struct {
    string name;
    bit    doRst;
    beat_t a;
    beat_t b;
    outs_t exp;
  } vec_t;

  int    passCount  = 0;
  int    checkCount = 0;
  vec_t  vecs[$];
  beat_t idle;

  function automatic beat_t bt(logic v, int addr, logic [31:0] data, logic last);
    beat_t r;
    r.v    = v;
    r.addr = 5'(addr);
    r.data = data;
    r.last = last;
    return r;
  endfunction

  function automatic outs_t ot(bit ra, bit rb, bit bsy, bit we, int addr, logic [31:0] data, bit s);
    outs_t r;
    r.readyA = ra;
    r.readyB = rb;
    r.busy   = bsy;
    r.wrEn   = we;
    r.wrAddr = 5'(addr);
    r.wrData = data;
    r.sel    = s;
    return r;
  endfunction

  task automatic addVec(string name, bit doRst, beat_t a, beat_t b, outs_t e);
    vec_t v;
    v.name  = name;
    v.doRst = doRst;
    v.a     = a;
    v.b     = b;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  task automatic checkVal(string name, string what, logic [31:0] act, logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, what, act, exp);
  endtask

  task automatic checkOutput(string name, outs_t e);
    checkVal(name, "readyA", 32'(bus.reqa_ready), 32'(e.readyA));
    checkVal(name, "readyB", 32'(bus.reqb_ready), 32'(e.readyB));
    checkVal(name, "busy",   32'(bus.busy),       32'(e.busy));
    checkVal(name, "wrEn",   32'(bus.wr_en),      32'(e.wrEn));
    checkVal(name, "wrAddr", 32'(bus.wr_addr),    32'(e.wrAddr));
    checkVal(name, "wrData", bus.wr_data,         e.wrData);
    checkVal(name, "sel",    32'(bus.sel),        32'(e.sel));
  endtask

  task automatic applyStimulus(beat_t a, beat_t b);
    bus.reqa_valid = a.v;
    bus.reqa_addr  = a.addr;
    bus.reqa_data  = a.data;
    bus.reqa_last  = a.last;
    bus.reqb_valid = b.v;
    bus.reqb_addr  = b.addr;
    bus.reqb_data  = b.data;
    bus.reqb_last  = b.last;
  endtask

  task automatic stepAndCheck(string name, outs_t e);
    @(posedge clk);
    #1;
    checkOutput(name, e);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(idle, idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Burst-level reference: who owns the port, how many beats it has had, and
  // who was served last; write-port expectations follow each accepted beat.
  int    own;
  int    served;
  bit    bWasLast;
  outs_t m;

  task automatic modelReset();
    own      = 0;
    served   = 0;
    bWasLast = 1'b1;
    m        = ot(0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic modelEdge(beat_t a, beat_t b, output bit tookA, output bit tookB);
    beat_t t;
    tookA = (own == 1) && a.v;
    tookB = (own == 2) && b.v;
    m.wrEn = 1'b0;
    if (own == 0) begin
      if (a.v && (!b.v || bWasLast)) own = 1;
      else if (b.v) own = 2;
    end else if (tookA || tookB) begin
      t        = tookA ? a : b;
      served   = served + 1;
      m.wrEn   = (t.addr != 0);
      m.wrAddr = t.addr;
      m.wrData = t.data;
      m.sel    = tookA;
      if (t.last || served == MAX_BURST) begin
        served   = 0;
        bWasLast = tookB;
        if (tookA) own = b.v ? 2 : 0;
        else       own = a.v ? 1 : 0;
      end
    end
    m.readyA = (own == 1);
    m.readyB = (own == 2);
    m.busy   = (own != 0);
  endtask

  initial begin
    beat_t pa;
    beat_t pb;
    beat_t qb;
    bit    tookA;
    bit    tookB;
    outs_t e;

    idle  = bt(0, 0, 32'h0, 0);
    rst_n = 1'b1;
    applyStimulus(idle, idle);
    #2;

    // Mid-traffic asynchronous reset.
    doReset();
    pa = bt(1, 8, 32'h88, 0);
    pb = bt(1, 9, 32'h99, 1);
    applyStimulus(pa, pb);
    stepAndCheck("preRstGrant", ot(1, 0, 1, 0, 0, 32'h0, 0));
    stepAndCheck("preRstWrite", ot(1, 0, 1, 1, 8, 32'h88, 1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst", ot(0, 0, 0, 0, 0, 32'h0, 0));
    stepAndCheck("rstHeld", ot(0, 0, 0, 0, 0, 32'h0, 0));
    @(negedge clk);
    applyStimulus(idle, idle);
    rst_n = 1'b1;

    // Directed vectors: inputs before an edge, outputs expected just after it.
    pa = bt(1, 5, 32'h1234, 1);
    addVec("rstA0", 0, pa, idle, ot(1, 0, 1, 0, 0, 32'h0, 0));
    addVec("rstA1", 0, pa, idle, ot(0, 0, 0, 1, 5, 32'h1234, 1));
    addVec("rstA2", 0, idle, idle, ot(0, 0, 0, 0, 5, 32'h1234, 1));

    pa = bt(1, 1, 32'hA1, 0);
    pb = bt(1, 3, 32'hB1, 0);
    addVec("tie0", 1, pa, pb, ot(1, 0, 1, 0, 0, 32'h0, 0));
    addVec("tie1", 0, pa, pb, ot(1, 0, 1, 1, 1, 32'hA1, 1));
    addVec("tie2", 0, bt(1, 2, 32'hA2, 1), pb, ot(0, 1, 1, 1, 2, 32'hA2, 1));
    addVec("tie3", 0, idle, pb, ot(0, 1, 1, 1, 3, 32'hB1, 0));
    addVec("tie4", 0, idle, bt(1, 4, 32'hB2, 1), ot(0, 0, 0, 1, 4, 32'hB2, 0));
    addVec("tie5", 0, idle, idle, ot(0, 0, 0, 0, 4, 32'hB2, 0));

    pb = bt(1, 20, 32'hB0, 1);
    addVec("force0", 1, bt(1, 10, 32'hA0, 0), pb, ot(1, 0, 1, 0, 0, 32'h0, 0));
    addVec("force1", 0, bt(1, 10, 32'hA0, 0), pb, ot(1, 0, 1, 1, 10, 32'hA0, 1));
    addVec("force2", 0, bt(1, 11, 32'hA1, 0), pb, ot(1, 0, 1, 1, 11, 32'hA1, 1));
    addVec("force3", 0, bt(1, 12, 32'hA2, 0), pb, ot(1, 0, 1, 1, 12, 32'hA2, 1));
    addVec("force4", 0, bt(1, 13, 32'hA3, 0), pb, ot(0, 1, 1, 1, 13, 32'hA3, 1));
    addVec("force5", 0, bt(1, 14, 32'hA4, 0), pb, ot(1, 0, 1, 1, 20, 32'hB0, 0));
    addVec("force6", 0, bt(1, 14, 32'hA4, 0), idle, ot(1, 0, 1, 1, 14, 32'hA4, 1));
    addVec("force7", 0, bt(1, 15, 32'hA5, 0), idle, ot(1, 0, 1, 1, 15, 32'hA5, 1));
    addVec("force8", 0, idle, idle, ot(1, 0, 1, 0, 15, 32'hA5, 1));

    pb = bt(1, 7, 32'h77, 1);
    qb = bt(1, 0, 32'h99, 1);
    addVec("zero0", 1, idle, pb, ot(0, 1, 1, 0, 0, 32'h0, 0));
    addVec("zero1", 0, idle, pb, ot(0, 0, 0, 1, 7, 32'h77, 0));
    addVec("zero2", 0, idle, qb, ot(0, 1, 1, 0, 7, 32'h77, 0));
    addVec("zero3", 0, idle, qb, ot(0, 0, 0, 0, 0, 32'h99, 0));

    pb = bt(1, 9, 32'hB9, 1);
    addVec("stall0", 1, bt(1, 1, 32'hC1, 0), pb, ot(1, 0, 1, 0, 0, 32'h0, 0));
    addVec("stall1", 0, bt(1, 1, 32'hC1, 0), pb, ot(1, 0, 1, 1, 1, 32'hC1, 1));
    addVec("stall2", 0, idle, pb, ot(1, 0, 1, 0, 1, 32'hC1, 1));
    addVec("stall3", 0, idle, pb, ot(1, 0, 1, 0, 1, 32'hC1, 1));
    addVec("stall4", 0, idle, pb, ot(1, 0, 1, 0, 1, 32'hC1, 1));
    addVec("stall5", 0, bt(1, 2, 32'hC2, 1), pb, ot(0, 1, 1, 1, 2, 32'hC2, 1));
    addVec("stall6", 0, idle, pb, ot(0, 0, 0, 1, 9, 32'hB9, 0));

    foreach (vecs[i]) begin
      if (vecs[i].doRst) doReset();
      applyStimulus(vecs[i].a, vecs[i].b);
      stepAndCheck(vecs[i].name, vecs[i].exp);
    end

    // Fairness: both sides always valid with single-beat bursts alternate A,B,A,B.
    doReset();
    applyStimulus(bt(1, 3, 32'hA, 1), bt(1, 4, 32'hB, 1));
    stepAndCheck("fairGrant", ot(1, 0, 1, 0, 0, 32'h0, 0));
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) e = ot(0, 1, 1, 1, 3, 32'hA, 1);
      else            e = ot(1, 0, 1, 1, 4, 32'hB, 0);
      stepAndCheck("fair", e);
    end

    // Randomized traffic: each side keeps a beat steady until it is accepted.
    doReset();
    modelReset();
    pa = idle;
    pb = idle;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!pa.v && $urandom_range(0, 9) < 6)
        pa = bt(1, int'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0));
      if (!pb.v && $urandom_range(0, 9) < 6)
        pb = bt(1, int'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0));
      applyStimulus(pa, pb);
      @(posedge clk);
      modelEdge(pa, pb, tookA, tookB);
      #1;
      checkOutput("random", m);
      if (tookA) pa = idle;
      if (tookB) pb = idle;
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
